// File: rtl/rsa_pkg.sv
// Shared types and defaults for the modular-exponentiation engine.
// Holds the FSM state encoding and the fixed-latency formula for constant-time mode.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        LOAD  = 3'd2,
        SQR   = 3'd3,
        MUL   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_e;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_EXP_WIDTH = 16;

    // Cycles from the accept edge to the done pulse when every multiply is executed.
    function automatic int modexp_latency(input int width, input int exp_width);
        return 2 + 2 * exp_width * (width + 1);
    endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, scanning a MSB first.
// One launch cycle loads the operands, then WIDTH iteration cycles; done marks the last one.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] p
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q, b_q, n_q, p_q;
    logic [WIDTH-1:0] p_d, dbl_r, add_r;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    // Inputs are below 2n, so the true remainder always fits in WIDTH bits.
    function automatic logic [WIDTH-1:0] mod_reduce(input logic [WIDTH+1:0] x,
                                                    input logic [WIDTH-1:0] m);
        return (x >= {2'b00, m}) ? (x[WIDTH-1:0] - m) : x[WIDTH-1:0];
    endfunction

    always_comb begin
        dbl_r = mod_reduce({1'b0, p_q, 1'b0}, n_q);
        add_r = mod_reduce({2'b00, dbl_r} + {2'b00, b_q}, n_q);
        p_d   = a_q[WIDTH-1] ? add_r : dbl_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start && !busy_q) begin
            a_q    <= a;
            b_q    <= b;
            n_q    <= n;
            p_q    <= '0;
            cnt_q  <= CW'(WIDTH);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            p_q   <= p_d;
            a_q   <= {a_q[WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(1));
    // The final product is presented combinationally in the done cycle.
    assign p    = p_d;

endmodule

// File: rtl/rsa_modexp_core.sv
// Left-to-right square-and-multiply modular exponentiation around rsa_modmul.
// start is a one-cycle request honoured only in IDLE; done is a one-cycle pulse with result/err valid.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int CONST_TIME = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 err,
    output logic [2:0]           dbg_state
);
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     base_q, mod_q, acc_q, acc_d, result_q, result_d;
    logic [EXP_WIDTH-1:0] expo_q;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 err_q, err_d, done_q, done_d;
    logic                 mm_start, mm_busy, mm_done;
    logic [WIDTH-1:0]     mm_b, mm_p;

    rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk   (clk),
        .rst   (rst),
        .start (mm_start),
        .a     (acc_q),
        .b     (mm_b),
        .n     (mod_q),
        .busy  (mm_busy),
        .done  (mm_done),
        .p     (mm_p)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        err_d    = err_q;
        mm_start = 1'b0;
        mm_b     = acc_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = CHECK;
                result_d = '0;
                err_d    = 1'b0;
            end
            CHECK: state_d = (mod_q < WIDTH'(2) || base_q >= mod_q) ? ERR : LOAD;
            LOAD: begin
                acc_d   = WIDTH'(1);
                idx_d   = IW'(EXP_WIDTH - 1);
                state_d = SQR;
            end
            SQR: begin
                mm_start = !mm_busy;
                if (mm_done) begin
                    acc_d = mm_p;
                    if (CONST_TIME != 0 || expo_q[idx_q]) state_d = MUL;
                    else if (idx_q == '0)                 state_d = DONE;
                    else                                  idx_d   = idx_q - IW'(1);
                end
            end
            MUL: begin
                mm_b     = base_q;
                mm_start = !mm_busy;
                // In constant-time mode the product is computed anyway and dropped for a 0 bit.
                if (mm_done) begin
                    if (expo_q[idx_q]) acc_d = mm_p;
                    if (idx_q == '0) state_d = DONE;
                    else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = SQR;
                    end
                end
            end
            DONE: state_d = IDLE;
            ERR: begin
                state_d  = IDLE;
                err_d    = 1'b1;
                result_d = '0;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DONE && state_q != DONE) result_d = acc_d;
        done_d = (state_d == DONE && state_q != DONE) || (state_q == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            mod_q    <= '0;
            expo_q   <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
            if (state_q == IDLE && start) begin
                base_q <= base;
                mod_q  <= modulus;
                expo_q <= exponent;
            end
        end
    end

    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = done_q;
    assign result    = result_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Randomized scoreboard bench for rsa_modexp_core: three instances (16/16 constant-time,
// 16/16 variable-time, 32/17 constant-time) checked against a right-to-left reference model.
module tb_rsa_modexp_core;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start0, start1, start2;
    logic [15:0] base0, exp0, mod0, result0;
    logic [15:0] base1, exp1, mod1, result1;
    logic [31:0] base2, mod2, result2;
    logic [16:0] exp2;
    logic        busy0, done0, err0, busy1, done1, err1, busy2, done2, err2;
    logic [2:0]  dbg0, dbg1, dbg2;

    rsa_modexp_core #(.WIDTH(16), .EXP_WIDTH(16), .CONST_TIME(1)) u_ct16 (
        .clk(clk), .rst(rst), .start(start0), .base(base0), .exponent(exp0), .modulus(mod0),
        .busy(busy0), .done(done0), .result(result0), .err(err0), .dbg_state(dbg0));

    rsa_modexp_core #(.WIDTH(16), .EXP_WIDTH(16), .CONST_TIME(0)) u_vt16 (
        .clk(clk), .rst(rst), .start(start1), .base(base1), .exponent(exp1), .modulus(mod1),
        .busy(busy1), .done(done1), .result(result1), .err(err1), .dbg_state(dbg1));

    rsa_modexp_core #(.WIDTH(32), .EXP_WIDTH(17), .CONST_TIME(1)) u_ct32 (
        .clk(clk), .rst(rst), .start(start2), .base(base2), .exponent(exp2), .modulus(mod2),
        .busy(busy2), .done(done2), .result(result2), .err(err2), .dbg_state(dbg2));

    // Scoreboard queues, one entry per issued request.
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    int          exp_lat_q[$];
    int          exp_inst_q[$];

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d, required %0d", name, act, req);
    endtask

    function automatic logic [31:0] ref_modexp(input longint unsigned b, input longint unsigned e,
                                               input longint unsigned m);
        longint unsigned r = 1;
        longint unsigned x = b % m;
        while (e != 0) begin
            if ((e & 1) != 0) r = (r * x) % m;
            x = (x * x) % m;
            e = e >> 1;
        end
        return 32'(r);
    endfunction

    task automatic launch(input int inst, input logic [31:0] b, input logic [31:0] e,
                          input logic [31:0] m);
        int          w;
        int          ew;
        bit          ct;
        logic [31:0] bm, em, mm;
        w  = (inst == 2) ? 32 : 16;
        ew = (inst == 2) ? 17 : 16;
        ct = (inst != 1);
        bm = (w == 32) ? b : (b & 32'h0000_FFFF);
        mm = (w == 32) ? m : (m & 32'h0000_FFFF);
        em = e & ((32'd1 << ew) - 32'd1);
        @(negedge clk);
        case (inst)
            0: begin base0 = bm[15:0]; exp0 = em[15:0]; mod0 = mm[15:0]; start0 = 1'b1; end
            1: begin base1 = bm[15:0]; exp1 = em[15:0]; mod1 = mm[15:0]; start1 = 1'b1; end
            default: begin base2 = bm; exp2 = em[16:0]; mod2 = mm; start2 = 1'b1; end
        endcase
        exp_inst_q.push_back(inst);
        if (mm < 2 || bm >= mm) begin
            exp_q.push_back(32'd0);
            exp_err_q.push_back(1'b1);
            exp_lat_q.push_back(2);
        end else begin
            exp_q.push_back(ref_modexp(bm, em, mm));
            exp_err_q.push_back(1'b0);
            exp_lat_q.push_back(ct ? 2 + 2 * ew * (w + 1) : 2 + (ew + $countones(em)) * (w + 1));
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int inst);
        bit seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk);
            seen = (inst == 0) ? done0 : ((inst == 1) ? done1 : done2);
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL timeout: instance %0d gave no done within 3000 cycles", inst);
            void'(exp_q.pop_front());
            void'(exp_err_q.pop_front());
            void'(exp_lat_q.pop_front());
            void'(exp_inst_q.pop_front());
        end
    endtask

    int          m_inst;
    logic [31:0] m_res;
    logic        m_err;

    always @(negedge clk) begin
        if (!rst && (done0 || done1 || done2)) begin
            m_inst = done0 ? 0 : (done1 ? 1 : 2);
            m_res  = done0 ? {16'h0, result0} : (done1 ? {16'h0, result1} : result2);
            m_err  = done0 ? err0 : (done1 ? err1 : err2);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: instance %0d result %0d, required no done", m_inst, m_res);
            end else begin
                check("instance", m_inst, exp_inst_q.pop_front());
                check("result", m_res, exp_q.pop_front());
                check("err", m_err, exp_err_q.pop_front());
                check("latency", cyc - acc_cyc, exp_lat_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] b, e, m, c;
        rst = 1'b1;
        {start0, start1, start2} = 3'b000;
        {base0, exp0, mod0, base1, exp1, mod1} = '0;
        {base2, exp2, mod2} = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy0", busy0, 0);
        check("reset_done0", done0, 0);
        check("reset_err0", err0, 0);
        check("reset_result0", result0, 0);
        check("reset_busy1", busy1, 0);
        check("reset_result1", result1, 0);
        check("reset_busy2", busy2, 0);
        check("reset_result2", result2, 0);
        rst = 1'b0;

        launch(0, 4, 13, 497);     wait_done(0);
        launch(0, 2, 10, 1000);    wait_done(0);
        launch(1, 2, 10, 1000);    wait_done(1);
        c = ref_modexp(1256, 5, 3551);
        launch(0, 1256, 5, 3551);  wait_done(0);
        launch(0, c, 1373, 3551);  wait_done(0);
        launch(1, c, 1373, 3551);  wait_done(1);
        launch(0, 3, 0, 7);        wait_done(0);
        launch(1, 3, 0, 7);        wait_done(1);
        launch(0, 9, 5, 7);        wait_done(0);
        launch(0, 0, 5, 1);        wait_done(0);
        launch(0, 65534, 65535, 65535); wait_done(0);

        // A second start while busy must not disturb the running operation.
        launch(0, 7, 16'hBEEF, 1009);
        repeat (30) @(negedge clk);
        base0 = 100; mod0 = 50; exp0 = 1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0);

        // Abort an operation with reset while it is squaring.
        launch(0, 4, 13, 497);
        repeat (10) @(negedge clk);
        check("busy_mid_op", busy0, 1);
        void'(exp_q.pop_back());
        void'(exp_err_q.pop_back());
        void'(exp_lat_q.pop_back());
        void'(exp_inst_q.pop_back());
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy0, 0);
        check("abort_result", result0, 0);
        check("abort_done", done0, 0);
        rst = 1'b0;
        launch(0, 4, 13, 497);     wait_done(0);

        for (int k = 0; k < 8; k++) begin
            m = $urandom_range(2, 65535);
            b = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, m - 1);
            e = $urandom_range(0, 65535);
            launch(k % 2, b, e, m);
            wait_done(k % 2);
        end

        launch(2, 65, 65537, 32'hFFFF_FFFB);          wait_done(2);
        launch(2, 32'hFFFF_FFFD, 17'h1FFFF, 32'hFFFF_FFFF); wait_done(2);
        for (int k = 0; k < 2; k++) begin
            m = $urandom;
            if (m < 2) m = 2;
            b = $urandom % m;
            e = $urandom_range(0, 131071);
            launch(2, b, e, m);
            wait_done(2);
        end

        repeat (5) @(negedge clk);
        check("leftover_expectations", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
